io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter_if.sv | 41 ++++
 rtl/io_bus_arbiter.sv | 97 +++++++++
 tb/tb_io_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle for io_bus_arbiter: core and DMA request ports plus the Stage-2/3 port into io_controller.
// The slave modport is the arbiter's view; master is the surrounding system.
interface io_bus_arbiter_if;
  logic [15:0] core_addr;
  logic [15:0] core_wdata;
  logic        core_read_req;
  logic        core_write_req;
  logic        core_stall;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ready;
  logic        dma_rvalid;
  logic [15:0] dma_rdata;

  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_read_req;
  logic        io_write_req;
  logic [15:0] io_rdata;

  modport slave (
    input  core_addr, core_wdata, core_read_req, core_write_req,
    output core_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output io_addr, io_wdata, io_read_req, io_write_req,
    input  io_rdata
  );

  modport master (
    output core_addr, core_wdata, core_read_req, core_write_req,
    input  core_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  io_addr, io_wdata, io_read_req, io_write_req,
    output io_rdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Arbitrates core and DMA I/O requests onto one io_controller port: core priority, DMA starvation
// guard, and a one-cycle bubble when a read follows a write to the same device.
module io_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  io_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {SRC_NONE, SRC_CORE, SRC_DMA} src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        last_wr;
  logic [10:0] last_wr_dev;
  logic        rd_pend;

  src_e        winner;
  logic        win_read;
  logic [15:0] win_addr;
  logic [15:0] win_wdata;
  logic        core_req;
  logic        run;
  logic        hazard;
  logic        issue;

  assign run      = clk_en & ~reset;
  assign core_req = bus.core_read_req | bus.core_write_req;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    winner    = SRC_NONE;
    win_read  = 1'b0;
    win_addr  = bus.core_addr;
    win_wdata = bus.core_wdata;
    if (bus.dma_req && (!core_req || starve_cnt == LIMIT)) begin
      winner    = SRC_DMA;
      win_read  = ~bus.dma_we;
      win_addr  = bus.dma_addr;
      win_wdata = bus.dma_wdata;
    end else if (core_req) begin
      winner   = SRC_CORE;
      win_read = bus.core_read_req;
    end
  end

  // Read-after-write to the same device needs one idle slot in io_controller; nobody else takes it.
  assign hazard = last_wr && win_read && (win_addr[14:4] == last_wr_dev);
  assign issue  = run && (winner != SRC_NONE) && !hazard;

  assign bus.io_addr      = win_addr;
  assign bus.io_wdata     = win_wdata;
  assign bus.io_read_req  = issue & win_read;
  assign bus.io_write_req = issue & ~win_read;

  assign bus.dma_ready  = issue && (winner == SRC_DMA);
  assign bus.core_stall = core_req && !(issue && (winner == SRC_CORE)) && !(clk_en && reset);

  // NOTE: reset is synchronous and qualified by clk_en, so it lives inside the enable branch.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) begin
        // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
        starve_cnt     <= '0;
        last_wr        <= 1'b0;
        last_wr_dev    <= '0;
        rd_pend        <= 1'b0;
        bus.dma_rvalid <= 1'b0;
        bus.dma_rdata  <= '0;
      end else begin
        if (!bus.dma_req || bus.dma_ready) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end

        if (issue) begin
          last_wr     <= ~win_read;
          last_wr_dev <= win_addr[14:4];
        end else begin
          last_wr <= 1'b0;
        end

        // io_rdata for a read issued last enabled cycle is valid now; capture it for the DMA.
        rd_pend        <= bus.dma_ready & ~bus.dma_we;
        bus.dma_rvalid <= rd_pend;
        if (rd_pend) begin
          bus.dma_rdata <= bus.io_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter with hand-computed expectations (STARVE_LIMIT = 7).
module tb_io_bus_arbiter;

  logic clk;
  logic reset;
  logic clk_en;
  int   checks;
  int   errors;

  io_bus_arbiter_if bus ();

  io_bus_arbiter #(.STARVE_LIMIT(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic core(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    bus.core_read_req  = rd;
    bus.core_write_req = wr;
    bus.core_addr      = addr;
    bus.core_wdata     = wdata;
  endtask

  task automatic dma(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    clk_en   = 1'b1;
    bus.io_rdata = 16'h0000;
    core(1'b0, 1'b1, 16'h0010, 16'h0001);
    dma(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Reset cycle: nothing issued, nobody stalled or granted
    #1;
    settle();
    check("rst_io_wr", bus.io_write_req, 0);
    check("rst_io_rd", bus.io_read_req, 0);
    check("rst_dma_ready", bus.dma_ready, 0);
    check("rst_core_stall", bus.core_stall, 0);
    step();
    check("rst_rvalid", bus.dma_rvalid, 0);
    check("rst_rdata", bus.dma_rdata, 0);
    check("rst_starve", dut.starve_cnt, 0);
    check("rst_last_wr", dut.last_wr, 0);
    reset = 1'b0;
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Core write, DMA idle: issued same cycle
    core(1'b0, 1'b1, 16'hFFF1, 16'h00AA);
    settle();
    check("cw_io_wr", bus.io_write_req, 1);
    check("cw_io_rd", bus.io_read_req, 0);
    check("cw_io_addr", bus.io_addr, 16'hFFF1);
    check("cw_io_wdata", bus.io_wdata, 16'h00AA);
    check("cw_core_stall", bus.core_stall, 0);
    step();
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    check("idle_io_wr", bus.io_write_req, 0);
    step();

    // Starvation: core reads continuously, DMA read held; DMA forced on the 8th cycle
    core(1'b1, 1'b0, 16'h0010, 16'h0000);
    dma(1'b1, 1'b0, 16'hFFE0, 16'h0000);
    for (int i = 1; i <= 7; i++) begin
      settle();
      check("starve_dma_ready", bus.dma_ready, 0);
      check("starve_io_addr", bus.io_addr, 16'h0010);
      check("starve_rvalid", bus.dma_rvalid, 0);
      step();
      check("starve_cnt", dut.starve_cnt, i);
    end
    settle();
    check("forced_dma_ready", bus.dma_ready, 1);
    check("forced_core_stall", bus.core_stall, 1);
    check("forced_io_rd", bus.io_read_req, 1);
    check("forced_io_addr", bus.io_addr, 16'hFFE0);
    step();
    check("forced_starve_clr", dut.starve_cnt, 0);

    // Read response: io_rdata at N+1, dma_rvalid/dma_rdata at N+2 for one cycle
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.io_rdata = 16'h1234;
    settle();
    check("resp_n1_rvalid", bus.dma_rvalid, 0);
    step();
    bus.io_rdata = 16'hBEEF;
    settle();
    check("resp_n2_rvalid", bus.dma_rvalid, 1);
    check("resp_n2_rdata", bus.dma_rdata, 16'h1234);
    step();
    settle();
    check("resp_n3_rvalid", bus.dma_rvalid, 0);
    check("resp_n3_rdata_hold", bus.dma_rdata, 16'h1234);

    // DMA write then core read to the same device: one bubble
    dma(1'b1, 1'b1, 16'hFFD2, 16'h00D2);
    settle();
    check("dw_dma_ready", bus.dma_ready, 1);
    check("dw_io_wr", bus.io_write_req, 1);
    check("dw_io_addr", bus.io_addr, 16'hFFD2);
    step();
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);
    core(1'b1, 1'b0, 16'hFFD4, 16'h0000);
    settle();
    check("bub_io_rd", bus.io_read_req, 0);
    check("bub_io_wr", bus.io_write_req, 0);
    check("bub_core_stall", bus.core_stall, 1);
    step();
    settle();
    check("bub_after_io_rd", bus.io_read_req, 1);
    check("bub_after_io_addr", bus.io_addr, 16'hFFD4);
    check("bub_after_core_stall", bus.core_stall, 0);
    step();

    // clk_en low mid DMA wait with a response showing: everything frozen
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    dma(1'b1, 1'b0, 16'h0030, 16'h0000);
    settle();
    check("ce_grant", bus.dma_ready, 1);
    step();
    core(1'b1, 1'b0, 16'h0020, 16'h0000);
    dma(1'b1, 1'b0, 16'h0040, 16'h0000);
    bus.io_rdata = 16'h5A5A;
    settle();
    check("ce_dma_denied", bus.dma_ready, 0);
    check("ce_core_go", bus.core_stall, 0);
    step();
    clk_en = 1'b0;
    bus.io_rdata = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ce_off_io_rd", bus.io_read_req, 0);
      check("ce_off_io_wr", bus.io_write_req, 0);
      check("ce_off_dma_ready", bus.dma_ready, 0);
      check("ce_off_core_stall", bus.core_stall, 1);
      step();
      check("ce_off_rvalid", bus.dma_rvalid, 1);
      check("ce_off_rdata", bus.dma_rdata, 16'h5A5A);
      check("ce_off_starve", dut.starve_cnt, 1);
    end
    clk_en = 1'b1;
    settle();
    check("ce_on_dma_ready", bus.dma_ready, 0);
    check("ce_on_io_addr", bus.io_addr, 16'h0020);
    step();
    check("ce_on_rvalid", bus.dma_rvalid, 0);
    check("ce_on_starve", dut.starve_cnt, 2);

    // DMA withdraws before grant: no transfer, counter cleared
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    check("wd_dma_ready", bus.dma_ready, 0);
    step();
    check("wd_starve", dut.starve_cnt, 0);

    // Core write + DMA read same device at the limit, then bubbled core read
    core(1'b1, 1'b0, 16'h0020, 16'h0000);
    dma(1'b1, 1'b0, 16'h0158, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      settle();
      check("lim_dma_wait", bus.dma_ready, 0);
      step();
    end
    core(1'b0, 1'b1, 16'h0150, 16'h7777);
    settle();
    check("lim_dma_ready", bus.dma_ready, 1);
    check("lim_io_rd", bus.io_read_req, 1);
    check("lim_io_addr", bus.io_addr, 16'h0158);
    check("lim_core_stall", bus.core_stall, 1);
    step();
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.io_rdata = 16'h4242;
    settle();
    check("lim_cw_io_wr", bus.io_write_req, 1);
    check("lim_cw_io_addr", bus.io_addr, 16'h0150);
    check("lim_cw_io_wdata", bus.io_wdata, 16'h7777);
    check("lim_cw_core_stall", bus.core_stall, 0);
    step();
    core(1'b1, 1'b0, 16'h015C, 16'h0000);
    dma(1'b1, 1'b1, 16'h0300, 16'h0003);
    settle();
    check("lim_bub_io_rd", bus.io_read_req, 0);
    check("lim_bub_io_wr", bus.io_write_req, 0);
    check("lim_bub_core_stall", bus.core_stall, 1);
    check("lim_bub_dma_ready", bus.dma_ready, 0);
    check("lim_bub_rvalid", bus.dma_rvalid, 1);
    check("lim_bub_rdata", bus.dma_rdata, 16'h4242);
    step();
    settle();
    check("lim_cr_io_rd", bus.io_read_req, 1);
    check("lim_cr_io_addr", bus.io_addr, 16'h015C);
    check("lim_cr_dma_ready", bus.dma_ready, 0);
    check("lim_cr_starve", dut.starve_cnt, 1);
    step();
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    check("lim_dw_dma_ready", bus.dma_ready, 1);
    step();
    check("lim_dw_starve", dut.starve_cnt, 0);

    // Reset the cycle after a DMA read grant: response dropped, state cleared
    dma(1'b1, 1'b0, 16'h0400, 16'h0000);
    settle();
    check("rg_dma_ready", bus.dma_ready, 1);
    step();
    reset = 1'b1;
    core(1'b0, 1'b1, 16'h0410, 16'h0041);
    dma(1'b1, 1'b0, 16'h0410, 16'h0000);
    bus.io_rdata = 16'h9999;
    settle();
    check("rg_rst_io_wr", bus.io_write_req, 0);
    check("rg_rst_io_rd", bus.io_read_req, 0);
    check("rg_rst_dma_ready", bus.dma_ready, 0);
    check("rg_rst_core_stall", bus.core_stall, 0);
    step();
    reset = 1'b0;
    core(1'b0, 1'b0, 16'h0000, 16'h0000);
    dma(1'b0, 1'b0, 16'h0000, 16'h0000);
    settle();
    check("rg_rvalid", bus.dma_rvalid, 0);
    check("rg_rdata", bus.dma_rdata, 0);
    check("rg_starve", dut.starve_cnt, 0);
    check("rg_last_wr", dut.last_wr, 0);
    step();
    check("rg_rvalid_late", bus.dma_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
